// File: rtl/spi_pkg.sv
// Shared SPI definitions: word width, responder FSM encoding and the word
// sent when a frame starts with nothing queued.
package spi_pkg;

  localparam int SPI_WORD_W = 16;

  localparam logic [SPI_WORD_W-1:0] UNDERRUN_WORD = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Power-of-two circular FIFO holding sample words until the SPI initiator
// pulls them; push into a full FIFO and pop from an empty one are ignored.
module sample_fifo
  import spi_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = SPI_WORD_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: non-blocking (<=) for every flop so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spi_responder.sv
// SPI responder (mode with sclk idling high): streams queued 16-bit samples
// MSB first on MISO, one word per CS_b frame, entirely in the sysclk domain.
module spi_responder
  import spi_pkg::*;
#(
  parameter  int DEPTH       = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int LW          = $clog2(DEPTH + 1)
) (
  input  logic                  sysclk,
  input  logic                  PRESET,
  input  logic                  sclk,
  input  logic                  CS_b,
  output logic                  MISO,
  input  logic [SPI_WORD_W-1:0] sample_data,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic [LW-1:0]         fill_level,
  output logic                  frame_done,
  output logic                  underrun,
  output logic                  abort
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] warm_sr;
  logic                   sclk_prev;
  logic                   cs_prev;
  logic                   armed;

  logic sclk_s, cs_s, warm;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign warm      = warm_sr[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;

  // warm_sr tracks when the synchronizers hold real samples rather than their
  // reset value, so a CS_b held low through reset can never arm a frame.
  always_ff @(posedge sysclk) begin
    if (PRESET) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      sclk_prev <= 1'b1;
      cs_prev   <= 1'b1;
      warm_sr   <= '0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_b};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      warm_sr   <= {warm_sr[SYNC_STAGES-2:0], 1'b1};
      if (warm && cs_s) armed <= 1'b1;
    end
  end

  spi_state_e            state;
  logic [SPI_WORD_W-1:0] shift_reg;
  logic [4:0]            bit_cnt;
  logic                  start;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [SPI_WORD_W-1:0] fifo_rdata;

  assign start = (state == ST_IDLE) && armed && cs_fall;

  sample_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(SPI_WORD_W)
  ) u_fifo (
    .clk  (sysclk),
    .rst  (PRESET),
    .push (sample_valid),
    .pop  (start),
    .wdata(sample_data),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(fill_level)
  );

  assign sample_ready = ~fifo_full;
  assign MISO         = (state == ST_SHIFT) & shift_reg[SPI_WORD_W-1];

  always_ff @(posedge sysclk) begin
    if (PRESET) begin
      state      <= ST_IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      abort      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      abort      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
            if (fifo_empty) begin
              shift_reg <= UNDERRUN_WORD;
              underrun  <= 1'b1;
            end else begin
              shift_reg <= fifo_rdata;
            end
          end
        end
        ST_SHIFT: begin
          // A CS_b rise landing on the 16th fall still completes the frame.
          if (sclk_fall && bit_cnt == 5'd15) begin
            bit_cnt    <= 5'd16;
            frame_done <= 1'b1;
            state      <= cs_rise ? ST_IDLE : ST_DONE;
          end else if (cs_rise) begin
            abort <= 1'b1;
            state <= ST_IDLE;
          end else begin
            if (sclk_fall) bit_cnt <= bit_cnt + 5'd1;
            if (sclk_rise && bit_cnt != 5'd0)
              shift_reg <= {shift_reg[SPI_WORD_W-2:0], 1'b0};
          end
        end
        ST_DONE: begin
          if (cs_rise) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: a bit-banged SPI initiator plus a queue
// scoreboard of words the responder is expected to return, in push order.
module tb_spi_responder;

  localparam int DEPTH = 4;
  localparam int HALF  = 32;  // sclk half-period in sysclk cycles (sysclk/64)

  logic        sysclk = 1'b0;
  logic        PRESET;
  logic        sclk;
  logic        CS_b;
  logic        MISO;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic [2:0]  fill_level;
  logic        frame_done;
  logic        underrun;
  logic        abort;

  spi_responder #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .sysclk      (sysclk),
    .PRESET      (PRESET),
    .sclk        (sclk),
    .CS_b        (CS_b),
    .MISO        (MISO),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .fill_level  (fill_level),
    .frame_done  (frame_done),
    .underrun    (underrun),
    .abort       (abort)
  );

  always #5 sysclk = ~sysclk;

  int total = 0;
  int bad   = 0;
  int n_done = 0, n_under = 0, n_abort = 0;
  logic [15:0] exp_q[$];

  always @(negedge sysclk) begin
    if (frame_done) n_done++;
    if (underrun)   n_under++;
    if (abort)      n_abort++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic push_word(input logic [15:0] w);
    bit accept;
    @(negedge sysclk);
    accept = (exp_q.size() < DEPTH);
    check("push_ready", sample_ready, accept);
    sample_data  = w;
    sample_valid = 1'b1;
    if (accept) exp_q.push_back(w);
    @(negedge sysclk);
    sample_valid = 1'b0;
    check("push_fill", fill_level, exp_q.size());
  endtask

  // One frame of nfalls sclk falls; coinc raises CS_b on the same sysclk
  // edge as the final fall. Scoreboard and pulse counters checked afterwards.
  task automatic run_frame(input string tag, input int nfalls, input bit coinc);
    logic [15:0] cap, exp_w;
    bit          exp_under;
    int          d0, u0, a0;
    bool_blk: begin end
    d0 = n_done; u0 = n_under; a0 = n_abort;
    exp_under = (exp_q.size() == 0);
    exp_w     = exp_under ? 16'h0000 : exp_q.pop_front();
    cap = '0;
    @(negedge sysclk);
    CS_b = 1'b0;
    wait_cycles(HALF);
    for (int i = 0; i < nfalls; i++) begin
      cap  = {cap[14:0], MISO};
      sclk = 1'b0;
      if (coinc && i == nfalls - 1) CS_b = 1'b1;
      wait_cycles(HALF);
      sclk = 1'b1;
      wait_cycles(HALF);
    end
    CS_b = 1'b1;
    wait_cycles(HALF);
    if (nfalls == 16) check({tag, "_word"}, cap, exp_w);
    check({tag, "_done"},  n_done - d0,  (nfalls == 16) ? 1 : 0);
    check({tag, "_abort"}, n_abort - a0, (nfalls == 16) ? 0 : 1);
    check({tag, "_under"}, n_under - u0, exp_under ? 1 : 0);
    check({tag, "_idle_miso"}, MISO, 1'b0);
    check({tag, "_fill"}, fill_level, exp_q.size());
  endtask

  initial begin
    int d0;
    PRESET = 1'b1; sclk = 1'b1; CS_b = 1'b1;
    sample_data = '0; sample_valid = 1'b0;
    wait_cycles(4);
    PRESET = 1'b0;
    wait_cycles(1);

    // reset state
    check("rst_miso",  MISO, 1'b0);
    check("rst_ready", sample_ready, 1'b1);
    check("rst_fill",  fill_level, 0);
    check("rst_pulses", {frame_done, underrun, abort}, 3'b000);
    wait_cycles(8);

    // single word round trip
    push_word(16'hA5C3);
    check("single_fill1", fill_level, 1);
    run_frame("single", 16, 1'b0);

    // empty FIFO -> underrun word
    run_frame("underrun", 16, 1'b0);

    // overfill: DEPTH accepted, the next dropped, then drained in order
    push_word(16'h1111);
    push_word(16'h2222);
    push_word(16'h3333);
    push_word(16'h4444);
    check("full_ready", sample_ready, 1'b0);
    push_word(16'h5555);
    check("full_fill", fill_level, DEPTH);
    for (int i = 0; i < DEPTH; i++) run_frame("drain", 16, 1'b0);

    // abort after 7 falls discards the loaded word
    push_word(16'h1234);
    push_word(16'h5678);
    run_frame("abort", 7, 1'b0);
    run_frame("after_abort", 16, 1'b0);

    // reset mid-frame with CS_b held low: no partial frame until CS_b cycles
    push_word(16'hCAFE);
    @(negedge sysclk);
    CS_b = 1'b0;
    wait_cycles(HALF);
    for (int i = 0; i < 5; i++) begin
      sclk = 1'b0; wait_cycles(HALF);
      sclk = 1'b1; wait_cycles(HALF);
    end
    PRESET = 1'b1;
    wait_cycles(3);
    PRESET = 1'b0;
    exp_q.delete();
    d0 = n_done;
    wait_cycles(1);
    check("prst_fill", fill_level, 0);
    for (int i = 0; i < 16; i++) begin
      check("prst_miso", MISO, 1'b0);
      sclk = 1'b0; wait_cycles(HALF);
      sclk = 1'b1; wait_cycles(HALF);
    end
    check("prst_no_done", n_done - d0, 0);
    CS_b = 1'b1;
    wait_cycles(HALF);
    push_word(16'hBEEF);
    run_frame("post_reset", 16, 1'b0);

    // CS_b rise coincident with the 16th fall completes the frame
    push_word(16'h0F0F);
    run_frame("coinc", 16, 1'b1);
    push_word(16'h8001);
    run_frame("after_coinc", 16, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
